p3: RTL and testbench

Execute stage of the SIMPLE pipeline, directly downstream of the p2 decode/register-read stage. It consumes p2's operands and control fields and computes the ALU/shift result. It keeps the S/Z/C/V flag register, resolves branches, and handles IN/OUT/HLT. Every control field is re-registered one cycle later for the memory stage.

---
 rtl/p3.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_p3.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/p3.sv
// p3: SIMPLE pipeline execute stage -- ALU/shifter, S/Z/C/V flag register, branch resolution, IN/OUT/HLT.
// Optional P3_SERIAL_SHIFT_EN selects an iterative one-bit-per-cycle shifter that stalls p2.
module p3 (
  input  logic        clockp3,
  input  logic        reset,
  input  logic        validin,
  input  logic        aluop,
  input  logic [15:0] alu1,
  input  logic [15:0] alu2,
  input  logic [3:0]  opcode,
  input  logic [3:0]  shamt,
  input  logic        writereg,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  regaddress,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  input  logic        isbranchin,
  input  logic [2:0]  condin,
  input  logic [15:0] inport,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        writeregout,
  output logic [1:0]  memwriteout,
  output logic [2:0]  regaddressout,
  output logic [15:0] addressout,
  output logic [15:0] storedataout,
  output logic        branchtaken,
  output logic        validout,
  output logic        stall,
  output logic        halted,
  output logic [15:0] outport,
  output logic        outstrobe
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        writeregout_q, writeregout_d;
  logic [1:0]  memwriteout_q, memwriteout_d;
  logic [2:0]  regaddressout_q, regaddressout_d;
  logic [15:0] addressout_q, addressout_d;
  logic [15:0] storedataout_q, storedataout_d;
  logic        branchtaken_q, branchtaken_d;
  logic        validout_q, validout_d;
  logic        halted_q, halted_d;
  logic [15:0] outport_q, outport_d;
  logic        outstrobe_q, outstrobe_d;

  logic [15:0] a, b;
  logic        accept, fire;
  logic [15:0] shift_res;
  logic        shift_c;
  logic [16:0] add_w, sub_w;
  logic [15:0] alu_r;
  logic        alu_c, alu_v, flag_wr, wr_kill;
  logic        cond_true, flag_s, flag_z, flag_v;

  assign a      = alu2;
  assign b      = alu1;
  assign accept = validin & ~halted_q;
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};

`ifdef P3_SERIAL_SHIFT_EN
  typedef enum logic {SH_IDLE, SH_SHIFT} sh_state_e;

  sh_state_e   sh_state_q, sh_state_d;
  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic [1:0]  sh_type_q, sh_type_d;
  logic        sh_c_q, sh_c_d;
  logic [15:0] step_in, step_out;
  logic [1:0]  step_type;
  logic        step_c, sh_start, sh_done;

  // The first bit is shifted on the entry edge, so the counter holds the bits still to go.
  assign sh_start  = (sh_state_q == SH_IDLE) & accept & aluop & (opcode[3:2] == 2'b10) & (shamt != 4'd0);
  assign sh_done   = (sh_state_q == SH_SHIFT) & (sh_cnt_q == 4'd0);
  assign fire      = ((sh_state_q == SH_IDLE) & accept & ~sh_start) | sh_done;
  assign stall     = ~reset & (sh_start | ((sh_state_q == SH_SHIFT) & (sh_cnt_q != 4'd0)));
  assign step_in   = (sh_state_q == SH_IDLE) ? a : sh_val_q;
  assign step_type = (sh_state_q == SH_IDLE) ? opcode[1:0] : sh_type_q;
  // Only a d = 0 shift reaches the ALU without the iterative path.
  assign shift_res = sh_done ? sh_val_q : a;
  assign shift_c   = sh_done & sh_c_q;

  always_comb begin
    step_out = step_in;
    step_c   = 1'b0;
    case (step_type)
      2'd0:    begin step_out = {step_in[14:0], 1'b0};        step_c = step_in[15]; end
      2'd1:    begin step_out = {step_in[14:0], step_in[15]}; step_c = step_in[15]; end
      2'd2:    begin step_out = {1'b0, step_in[15:1]};        step_c = step_in[0];  end
      default: begin step_out = {step_in[15], step_in[15:1]}; step_c = step_in[0];  end
    endcase
  end

  always_comb begin
    sh_state_d = sh_state_q;
    sh_val_d   = sh_val_q;
    sh_cnt_d   = sh_cnt_q;
    sh_type_d  = sh_type_q;
    sh_c_d     = sh_c_q;
    if (sh_start) begin
      sh_state_d = SH_SHIFT;
      sh_val_d   = step_out;
      sh_c_d     = step_c;
      sh_cnt_d   = shamt - 4'd1;
      sh_type_d  = opcode[1:0];
    end else if (sh_state_q == SH_SHIFT) begin
      if (sh_cnt_q != 4'd0) begin
        sh_val_d = step_out;
        sh_c_d   = step_c;
        sh_cnt_d = sh_cnt_q - 4'd1;
      end else begin
        sh_state_d = SH_IDLE;
      end
    end
  end

  always_ff @(posedge clockp3 or posedge reset) begin
    if (reset) begin
      sh_state_q <= SH_IDLE;
      sh_val_q   <= 16'h0000;
      sh_cnt_q   <= 4'd0;
      sh_type_q  <= 2'd0;
      sh_c_q     <= 1'b0;
    end else begin
      sh_state_q <= sh_state_d;
      sh_val_q   <= sh_val_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_type_q  <= sh_type_d;
      sh_c_q     <= sh_c_d;
    end
  end
`else
  logic [31:0]        sll_w, rot_w, srl_w;
  logic signed [31:0] sra_w;

  // Widened shifts leave the last bit shifted out at a fixed position (zero when d = 0).
  assign sll_w = {16'h0000, a} << shamt;
  assign rot_w = {a, a} << shamt;
  assign srl_w = {a, 16'h0000} >> shamt;
  assign sra_w = $signed({a, 16'h0000}) >>> shamt;
  assign fire  = accept;
  assign stall = 1'b0;

  always_comb begin
    shift_res = a;
    shift_c   = 1'b0;
    case (opcode[1:0])
      2'd0:    begin shift_res = sll_w[15:0];  shift_c = sll_w[16]; end
      2'd1:    begin shift_res = rot_w[31:16]; shift_c = (shamt != 4'd0) & rot_w[16]; end
      2'd2:    begin shift_res = srl_w[31:16]; shift_c = srl_w[15]; end
      default: begin shift_res = sra_w[31:16]; shift_c = sra_w[15]; end
    endcase
  end
`endif

  always_comb begin
    alu_r   = a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    flag_wr = 1'b0;
    wr_kill = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_r   = add_w[15:0];
        alu_c   = add_w[16];
        alu_v   = (a[15] == b[15]) & (add_w[15] != a[15]);
        flag_wr = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_r   = sub_w[15:0];
        alu_c   = sub_w[16];
        alu_v   = (a[15] != b[15]) & (sub_w[15] != a[15]);
        flag_wr = 1'b1;
        wr_kill = (opcode == OP_CMP);
      end
      OP_AND: begin alu_r = a & b; flag_wr = 1'b1; end
      OP_OR:  begin alu_r = a | b; flag_wr = 1'b1; end
      OP_XOR: begin alu_r = a ^ b; flag_wr = 1'b1; end
      OP_MOV: begin alu_r = b;     flag_wr = 1'b1; end
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
        alu_r   = shift_res;
        alu_c   = shift_c;
        flag_wr = 1'b1;
      end
      OP_IN:   alu_r = inport;
      default: wr_kill = 1'b1;
    endcase
  end

  assign flag_s = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_true = 1'b0;
    if (condin == 3'b100) begin
      cond_true = 1'b1;
    end else if (condin == 3'b111) begin
      case (regaddress)
        3'b000:  cond_true = flag_z;
        3'b001:  cond_true = flag_s ^ flag_v;
        3'b010:  cond_true = flag_z | (flag_s ^ flag_v);
        3'b011:  cond_true = ~flag_z;
        default: cond_true = 1'b0;
      endcase
    end
  end

  // Bubbles and halted cycles clear the side-effecting outputs and hold the data outputs.
  always_comb begin
    result_d        = result_q;
    flags_d         = flags_q;
    writeregout_d   = 1'b0;
    memwriteout_d   = 2'b00;
    regaddressout_d = regaddressout_q;
    addressout_d    = addressout_q;
    storedataout_d  = storedataout_q;
    branchtaken_d   = 1'b0;
    validout_d      = 1'b0;
    halted_d        = halted_q;
    outport_d       = outport_q;
    outstrobe_d     = 1'b0;
    if (fire) begin
      validout_d      = 1'b1;
      writeregout_d   = writereg;
      memwriteout_d   = memwrite;
      regaddressout_d = regaddress;
      addressout_d    = address;
      storedataout_d  = storedata;
      branchtaken_d   = isbranchin & cond_true;
      if (aluop) begin
        result_d = alu_r;
        if (flag_wr) flags_d = {alu_r[15], (alu_r == 16'h0000), alu_c, alu_v};
        if (wr_kill) writeregout_d = 1'b0;
        if (opcode == OP_OUT) begin
          outport_d   = b;
          outstrobe_d = 1'b1;
        end
        if (opcode == OP_HLT) halted_d = 1'b1;
      end else begin
        result_d = a;
      end
    end
  end

  always_ff @(posedge clockp3 or posedge reset) begin
    if (reset) begin
      result_q        <= 16'h0000;
      flags_q         <= 4'b0000;
      writeregout_q   <= 1'b0;
      memwriteout_q   <= 2'b00;
      regaddressout_q <= 3'b000;
      addressout_q    <= 16'h0000;
      storedataout_q  <= 16'h0000;
      branchtaken_q   <= 1'b0;
      validout_q      <= 1'b0;
      halted_q        <= 1'b0;
      outport_q       <= 16'h0000;
      outstrobe_q     <= 1'b0;
    end else begin
      result_q        <= result_d;
      flags_q         <= flags_d;
      writeregout_q   <= writeregout_d;
      memwriteout_q   <= memwriteout_d;
      regaddressout_q <= regaddressout_d;
      addressout_q    <= addressout_d;
      storedataout_q  <= storedataout_d;
      branchtaken_q   <= branchtaken_d;
      validout_q      <= validout_d;
      halted_q        <= halted_d;
      outport_q       <= outport_d;
      outstrobe_q     <= outstrobe_d;
    end
  end

  assign result        = result_q;
  assign flags         = flags_q;
  assign writeregout   = writeregout_q;
  assign memwriteout   = memwriteout_q;
  assign regaddressout = regaddressout_q;
  assign addressout    = addressout_q;
  assign storedataout  = storedataout_q;
  assign branchtaken   = branchtaken_q;
  assign validout      = validout_q;
  assign halted        = halted_q;
  assign outport       = outport_q;
  assign outstrobe     = outstrobe_q;

endmodule

// File: tb/tb_p3.sv
// Self-checking bench for p3: directed cases plus randomized instructions against an arithmetic reference model.
module tb_p3;

  logic        clockp3, reset, validin, aluop, writereg, isbranchin;
  logic [15:0] alu1, alu2, address, storedata, inport;
  logic [3:0]  opcode, shamt;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress, condin;
  logic [15:0] result, addressout, storedataout, outport;
  logic [3:0]  flags;
  logic        writeregout, branchtaken, validout, stall, halted, outstrobe;
  logic [1:0]  memwriteout;
  logic [2:0]  regaddressout;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  logic [3:0]  m_flags;
  logic        m_halted;
  logic [15:0] m_outport, m_result;
  bit          m_res_known;

  typedef struct {
    logic v, al, wr, br;
    logic [15:0] a1, a2, ad, sd, inp;
    logic [3:0]  op, d;
    logic [1:0]  mw;
    logic [2:0]  ra, cd;
  } instr_t;

  p3 dut (
    .clockp3(clockp3), .reset(reset), .validin(validin), .aluop(aluop),
    .alu1(alu1), .alu2(alu2), .opcode(opcode), .shamt(shamt),
    .writereg(writereg), .memwrite(memwrite), .regaddress(regaddress),
    .address(address), .storedata(storedata), .isbranchin(isbranchin),
    .condin(condin), .inport(inport), .result(result), .flags(flags),
    .writeregout(writeregout), .memwriteout(memwriteout), .regaddressout(regaddressout),
    .addressout(addressout), .storedataout(storedataout), .branchtaken(branchtaken),
    .validout(validout), .stall(stall), .halted(halted), .outport(outport),
    .outstrobe(outstrobe)
  );

  initial clockp3 = 1'b0;
  always #5 clockp3 = ~clockp3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic al, input logic [3:0] op,
                                input logic [15:0] a2, input logic [15:0] a1, input logic [3:0] d);
    instr_t t;
    t.v = v; t.al = al; t.op = op; t.a2 = a2; t.a1 = a1; t.d = d;
    t.wr = 1'b1; t.br = 1'b0; t.ad = 16'h0; t.sd = 16'h0; t.inp = 16'h0;
    t.mw = 2'b00; t.ra = 3'b000; t.cd = 3'b000;
    return t;
  endfunction

  // Reference ALU: plain integer arithmetic on the operand values.
  function automatic void model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] d, input logic [15:0] inp,
                                    output logic [15:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, t, n;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b)); n = int'(d);
    r = a; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        t = ua + ub; r = 16'(t); c = (t > 65535);
        t = sa + sb; v = (t > 32767) || (t < -32768);
      end
      4'd1, 4'd5: begin
        t = ua - ub; r = 16'(t); c = (ua < ub);
        t = sa - sb; v = (t > 32767) || (t < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = b;
      4'd8: begin r = 16'(ua * (1 << n)); c = (n > 0) ? (((ua >> (16 - n)) & 1) != 0) : 1'b0; end
      4'd9: begin
        r = 16'((ua << n) | (ua >> (16 - n)));
        c = (n > 0) ? (((ua >> (16 - n)) & 1) != 0) : 1'b0;
      end
      4'd10: begin r = 16'(ua >> n);  c = (n > 0) ? (((ua >> (n - 1)) & 1) != 0) : 1'b0; end
      4'd11: begin r = 16'(sa >>> n); c = (n > 0) ? (((ua >> (n - 1)) & 1) != 0) : 1'b0; end
      4'd12: r = inp;
      default: r = a;
    endcase
  endfunction

  function automatic bit model_branch(input logic [2:0] cd, input logic [2:0] ra, input logic [3:0] f);
    bit s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    if (cd == 3'b100) return 1'b1;
    if (cd != 3'b111) return 1'b0;
    case (ra)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input instr_t t);
    validin = t.v; aluop = t.al; opcode = t.op; alu2 = t.a2; alu1 = t.a1; shamt = t.d;
    writereg = t.wr; memwrite = t.mw; regaddress = t.ra; address = t.ad; storedata = t.sd;
    isbranchin = t.br; condin = t.cd; inport = t.inp;
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_halted = 1'b0; m_outport = 16'h0; m_result = 16'h0; m_res_known = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_result", result, 16'h0);
    check_eq("rst_flags", flags, 4'h0);
    check_eq("rst_writeregout", writeregout, 0);
    check_eq("rst_memwriteout", memwriteout, 0);
    check_eq("rst_regaddressout", regaddressout, 0);
    check_eq("rst_addressout", addressout, 0);
    check_eq("rst_storedataout", storedataout, 0);
    check_eq("rst_branchtaken", branchtaken, 0);
    check_eq("rst_validout", validout, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_outport", outport, 0);
    check_eq("rst_outstrobe", outstrobe, 0);
    @(posedge clockp3); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_instr(input instr_t t);
    logic [15:0] er;
    logic ec, ev, valid_exp, wr_exp, bt_exp, os_exp;
    logic [1:0] mw_exp;
    int exp_st, st;
    drive(t);
    exp_st = 0;
`ifdef P3_SERIAL_SHIFT_EN
    if (t.v && t.al && !m_halted && t.op >= 4'd8 && t.op <= 4'd11 && t.d != 4'd0) exp_st = int'(t.d);
`endif
    valid_exp = t.v && !m_halted;
    wr_exp = 1'b0; mw_exp = 2'b00; bt_exp = 1'b0; os_exp = 1'b0;
    if (valid_exp) begin
      mw_exp = t.mw;
      bt_exp = t.br && model_branch(t.cd, t.ra, m_flags);
      wr_exp = t.wr;
      if (!t.al) begin
        m_result = t.a2; m_res_known = 1'b1;
      end else begin
        model_alu(t.op, t.a2, t.a1, t.d, t.inp, er, ec, ev);
        if (t.op == 4'd5 || t.op == 4'd7 || t.op >= 4'd13) wr_exp = 1'b0;
        m_res_known = (t.op != 4'd7) && (t.op < 4'd13);
        m_result = er;
        if (t.op <= 4'd6 || (t.op >= 4'd8 && t.op <= 4'd11))
          m_flags = {er[15], (er == 16'h0), ec, ev};
        if (t.op == 4'd13) begin m_outport = t.a1; os_exp = 1'b1; end
        if (t.op == 4'd15) m_halted = 1'b1;
      end
    end
    st = 0;
    while (stall === 1'b1 && st < 40) begin
      @(posedge clockp3); #1;
      st++;
      check_eq("validout_while_stalled", validout, 0);
    end
    check_eq("stall_cycles", st, exp_st);
    @(posedge clockp3); #1;
    n_txn++;
    $display("txn %0d v=%0b alu=%0b op=%0d a=%h b=%h d=%0d br=%0b -> result=%h flags=%b valid=%0b bt=%0b",
             n_txn, t.v, t.al, t.op, t.a2, t.a1, t.d, t.br, result, flags, validout, branchtaken);
    check_eq("validout", validout, valid_exp);
    check_eq("writeregout", writeregout, wr_exp);
    check_eq("memwriteout", memwriteout, mw_exp);
    check_eq("branchtaken", branchtaken, bt_exp);
    check_eq("outstrobe", outstrobe, os_exp);
    check_eq("flags", flags, m_flags);
    check_eq("halted", halted, m_halted);
    check_eq("outport", outport, m_outport);
    if (m_res_known) check_eq("result", result, m_result);
    if (valid_exp) begin
      check_eq("regaddressout", regaddressout, t.ra);
      check_eq("addressout", addressout, t.ad);
      check_eq("storedataout", storedataout, t.sd);
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] edges [4];
    edges[0] = 16'h0000; edges[1] = 16'h7FFF; edges[2] = 16'h8000; edges[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    instr_t t;
    reset = 1'b0;
    drive(mk(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0));
    model_reset();
    #3;
    apply_reset();

    run_instr(mk(1'b1, 1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd0));
    check_eq("add_const_result", result, 16'h8000);
    check_eq("add_const_flags", flags, 4'b1001);
    run_instr(mk(1'b1, 1'b1, 4'd1, 16'h0003, 16'h0003, 4'd0));
    check_eq("sub_const_flags", flags, 4'b0100);

    run_instr(mk(1'b1, 1'b1, 4'd5, 16'h0002, 16'h0005, 4'd0));
    check_eq("cmp_const_writeregout", writeregout, 0);
    t = mk(1'b1, 1'b0, 4'd0, 16'h0040, 16'h0000, 4'd0);
    t.br = 1'b1; t.cd = 3'b111; t.ra = 3'b001; t.wr = 1'b0;
    run_instr(t);
    check_eq("blt_const_taken", branchtaken, 1);

    run_instr(mk(1'b1, 1'b1, 4'd11, 16'h8001, 16'h0000, 4'd4));
    check_eq("sra_const_result", result, 16'hF800);
    check_eq("sra_const_flags", flags, 4'b1000);
    run_instr(mk(1'b1, 1'b1, 4'd9, 16'h8001, 16'h0000, 4'd1));
    check_eq("slr_const_result", result, 16'h0003);
    check_eq("slr_const_flags", flags, 4'b0010);

    run_instr(mk(1'b1, 1'b1, 4'd13, 16'h0000, 16'h1234, 4'd0));
    check_eq("out_const_outport", outport, 16'h1234);
    run_instr(mk(1'b0, 1'b1, 4'd13, 16'h0000, 16'h1234, 4'd0));
    t = mk(1'b1, 1'b1, 4'd12, 16'h0000, 16'h0000, 4'd0);
    t.inp = 16'hABCD;
    run_instr(t);
    check_eq("in_const_result", result, 16'hABCD);

    for (int i = 0; i < 400; i++) begin
      t = mk(($urandom_range(0, 4) != 0), 1'($urandom), 4'($urandom_range(0, 14)),
             rand_operand(), rand_operand(), 4'($urandom));
      t.wr = 1'($urandom); t.mw = 2'($urandom); t.ra = 3'($urandom);
      t.ad = 16'($urandom); t.sd = 16'($urandom); t.inp = 16'($urandom);
      t.br = !t.al && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: t.cd = 3'b100;
        1, 2: t.cd = 3'b111;
        default: t.cd = 3'($urandom);
      endcase
      run_instr(t);
    end

    run_instr(mk(1'b1, 1'b1, 4'd15, 16'h0000, 16'h0000, 4'd0));
    check_eq("hlt_const_halted", halted, 1);
    for (int i = 0; i < 5; i++) run_instr(mk(1'b1, 1'b1, 4'd0, 16'h1111, 16'h2222, 4'd0));
    apply_reset();
    run_instr(mk(1'b1, 1'b1, 4'd0, 16'h0002, 16'h0003, 4'd0));

    drive(mk(1'b1, 1'b1, 4'd10, 16'hF0F0, 16'h0000, 4'd8));
    repeat (3) begin @(posedge clockp3); #1; end
    apply_reset();
    run_instr(mk(1'b1, 1'b1, 4'd0, 16'h0002, 16'h0003, 4'd0));
    check_eq("post_abort_result", result, 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
